// File: rtl/counter_pkg.sv
// counter_pkg: shared constants for the up/down counter slice.
//   DIR_UP / DIR_DOWN     : encodings for the up_dn input
//   MODE_WRAP / MODE_SAT  : encodings for the sat input
//   DEFAULT_WIDTH         : default counter width in bits
package counter_pkg;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT = 1'b1;
    localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/prescaler_tick.sv
// prescaler_tick: divides enabled clk cycles into one tick every PRESCALE cycles.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, phase returns to 0
//   en    : advances the phase; the phase holds when low
//   clr   : synchronous clear of the phase, takes priority over en
//   tick  : high while en=1 and the phase is at PRESCALE-1
module prescaler_tick #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    assign tick = en && phase == LAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) phase <= '0;
        else if (clr) phase <= '0;
        else if (en) phase <= tick ? '0 : phase + PW'(1);
    end
endmodule

// File: rtl/mod_updn_counter.sv
// mod_updn_counter: prescaled up/down counter over 0..modulus with wrap or saturate.
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset (count, tc, prescaler to 0)
//   en       : count enable, gates prescaler and steps
//   up_dn    : 1 count up, 0 count down
//   sat      : 1 saturate at the boundary, 0 wrap
//   load     : synchronous load strobe, overrides en
//   load_val : value loaded, clipped to modulus
//   modulus  : top count value
//   count    : registered count
//   tc       : registered one-cycle terminal-count pulse
//   zero     : combinational, high when count is 0
module mod_updn_counter #(
    parameter int WIDTH = counter_pkg::DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero
);
    import counter_pkg::*;

    logic             tick;
    logic             step;
    logic             at_top;
    logic             at_zero;
    logic             above;
    logic [WIDTH-1:0] next_count;
    logic             next_tc;

    prescaler_tick #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );

    assign step = en && !load && tick;
    assign at_top = count == modulus;
    assign at_zero = count == '0;
    assign above = count > modulus;
    assign zero = at_zero;

    // A count left above a lowered modulus re-enters the range at the edge
    // facing the step direction; it is not a boundary step, so no tc.
    always_comb begin
        next_count = count;
        next_tc = 1'b0;
        if (load) begin
            next_count = load_val > modulus ? modulus : load_val;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                next_count = above ? '0 : at_top ? (sat == MODE_SAT ? modulus : '0) : count + WIDTH'(1);
                next_tc = at_top;
            end else begin
                next_count = above ? modulus : at_zero ? (sat == MODE_SAT ? '0 : modulus) : count - WIDTH'(1);
                next_tc = at_zero;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            tc <= 1'b0;
        end else begin
            count <= next_count;
            tc <= next_tc;
        end
    end
endmodule

// File: tb/tb_mod_updn_counter.sv
module tb_mod_updn_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       sat = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] modulus = 4'd9;
    logic [3:0] count1, count3;
    logic       tc1, tc3, zero1, zero3;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mod_updn_counter #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
        .load_val(load_val), .modulus(modulus), .count(count1), .tc(tc1), .zero(zero1)
    );

    mod_updn_counter #(.WIDTH(4), .PRESCALE(3)) dut3 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
        .load_val(load_val), .modulus(modulus), .count(count3), .tc(tc3), .zero(zero3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v, input logic [3:0] m);
        load = 1'b1;
        load_val = v;
        modulus = m;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b1;
        up_dn = 1'b1;
        sat = 1'b0;
        modulus = 4'd9;
        repeat (2) tick();
        checks += 4;
        if (count1 !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count1); end
        if (tc1 !== 1'b0) begin failures++; $display("FAIL reset_tc got=%0b exp=0", tc1); end
        if (zero1 !== 1'b1) begin failures++; $display("FAIL reset_zero got=%0b exp=1", zero1); end
        if (count3 !== 4'd0) begin failures++; $display("FAIL reset_count3 got=%0d exp=0", count3); end
        reset = 1'b0;
    endtask

    task automatic test_wrap_up();
        int exp_c [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        for (int i = 0; i < 12; i++) begin
            tick();
            checks += 2;
            if (count1 !== 4'(exp_c[i])) begin failures++; $display("FAIL wrap_up_count[%0d] got=%0d exp=%0d", i, count1, exp_c[i]); end
            if (tc1 !== (i == 9)) begin failures++; $display("FAIL wrap_up_tc[%0d] got=%0b exp=%0b", i, tc1, i == 9); end
        end
    endtask

    task automatic test_sat_down();
        int exp_c [4] = '{1, 0, 0, 0};
        logic exp_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic exp_z [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        sat = 1'b1;
        up_dn = 1'b0;
        do_load(4'd2, 4'd9);
        checks += 3;
        if (count1 !== 4'd2) begin failures++; $display("FAIL sat_down_load got=%0d exp=2", count1); end
        if (tc1 !== 1'b0) begin failures++; $display("FAIL sat_down_load_tc got=%0b exp=0", tc1); end
        if (zero1 !== 1'b0) begin failures++; $display("FAIL sat_down_load_zero got=%0b exp=0", zero1); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 3;
            if (count1 !== 4'(exp_c[i])) begin failures++; $display("FAIL sat_down_count[%0d] got=%0d exp=%0d", i, count1, exp_c[i]); end
            if (tc1 !== exp_t[i]) begin failures++; $display("FAIL sat_down_tc[%0d] got=%0b exp=%0b", i, tc1, exp_t[i]); end
            if (zero1 !== exp_z[i]) begin failures++; $display("FAIL sat_down_zero[%0d] got=%0b exp=%0b", i, zero1, exp_z[i]); end
        end
    endtask

    task automatic test_load_clip();
        sat = 1'b0;
        up_dn = 1'b1;
        do_load(4'd15, 4'd9);
        checks += 4;
        if (count1 !== 4'd9) begin failures++; $display("FAIL load_clip_count got=%0d exp=9", count1); end
        if (tc1 !== 1'b0) begin failures++; $display("FAIL load_clip_tc got=%0b exp=0", tc1); end
        tick();
        if (count1 !== 4'd0) begin failures++; $display("FAIL load_clip_step got=%0d exp=0", count1); end
        if (tc1 !== 1'b1) begin failures++; $display("FAIL load_clip_step_tc got=%0b exp=1", tc1); end
    endtask

    task automatic test_boundaries();
        up_dn = 1'b0;
        sat = 1'b0;
        do_load(4'd0, 4'd9);
        tick();
        checks += 2;
        if (count1 !== 4'd9) begin failures++; $display("FAIL wrap_down_count got=%0d exp=9", count1); end
        if (tc1 !== 1'b1) begin failures++; $display("FAIL wrap_down_tc got=%0b exp=1", tc1); end
        up_dn = 1'b1;
        sat = 1'b1;
        do_load(4'd9, 4'd9);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks += 2;
            if (count1 !== 4'd9) begin failures++; $display("FAIL sat_up_count[%0d] got=%0d exp=9", i, count1); end
            if (tc1 !== 1'b1) begin failures++; $display("FAIL sat_up_tc[%0d] got=%0b exp=1", i, tc1); end
        end
        sat = 1'b0;
        do_load(4'd5, 4'd0);
        checks += 1;
        if (count1 !== 4'd0) begin failures++; $display("FAIL mod0_load got=%0d exp=0", count1); end
        for (int i = 0; i < 2; i++) begin
            up_dn = (i == 0);
            tick();
            checks += 2;
            if (count1 !== 4'd0) begin failures++; $display("FAIL mod0_count[%0d] got=%0d exp=0", i, count1); end
            if (tc1 !== 1'b1) begin failures++; $display("FAIL mod0_tc[%0d] got=%0b exp=1", i, tc1); end
        end
        up_dn = 1'b1;
        do_load(4'd9, 4'd9);
        en = 1'b0;
        tick();
        checks += 2;
        if (count1 !== 4'd9) begin failures++; $display("FAIL hold_count got=%0d exp=9", count1); end
        if (tc1 !== 1'b0) begin failures++; $display("FAIL hold_tc got=%0b exp=0", tc1); end
        en = 1'b1;
        tick();
        checks += 2;
        if (count1 !== 4'd0) begin failures++; $display("FAIL resume_count got=%0d exp=0", count1); end
        if (tc1 !== 1'b1) begin failures++; $display("FAIL resume_tc got=%0b exp=1", tc1); end
    endtask

    task automatic test_modulus_change();
        sat = 1'b0;
        up_dn = 1'b1;
        do_load(4'd7, 4'd15);
        modulus = 4'd4;
        tick();
        checks += 2;
        if (count1 !== 4'd0) begin failures++; $display("FAIL mod_lower_up got=%0d exp=0", count1); end
        do_load(4'd7, 4'd15);
        up_dn = 1'b0;
        modulus = 4'd4;
        tick();
        if (count1 !== 4'd4) begin failures++; $display("FAIL mod_lower_down got=%0d exp=4", count1); end
    endtask

    task automatic test_prescale();
        logic en_pat [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int exp_c [11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
        en = 1'b1;
        up_dn = 1'b1;
        sat = 1'b0;
        do_load(4'd0, 4'd15);
        checks += 1;
        if (count3 !== 4'd0) begin failures++; $display("FAIL prescale_load got=%0d exp=0", count3); end
        for (int i = 0; i < 11; i++) begin
            en = en_pat[i];
            tick();
            checks += 1;
            if (count3 !== 4'(exp_c[i])) begin failures++; $display("FAIL prescale_count[%0d] got=%0d exp=%0d", i, count3, exp_c[i]); end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_async();
        int exp_c [3] = '{0, 0, 1};
        en = 1'b1;
        up_dn = 1'b1;
        do_load(4'd5, 4'd15);
        tick();
        checks += 1;
        if (count3 !== 4'd5) begin failures++; $display("FAIL async_pre_count got=%0d exp=5", count3); end
        #2;
        reset = 1'b1;
        #1;
        checks += 3;
        if (count3 !== 4'd0) begin failures++; $display("FAIL async_count3 got=%0d exp=0", count3); end
        if (tc3 !== 1'b0) begin failures++; $display("FAIL async_tc3 got=%0b exp=0", tc3); end
        if (count1 !== 4'd0) begin failures++; $display("FAIL async_count1 got=%0d exp=0", count1); end
        load = 1'b1;
        load_val = 4'd9;
        tick();
        checks += 2;
        if (count3 !== 4'd0) begin failures++; $display("FAIL reset_ignore3 got=%0d exp=0", count3); end
        if (count1 !== 4'd0) begin failures++; $display("FAIL reset_ignore1 got=%0d exp=0", count1); end
        reset = 1'b0;
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 1;
            if (count3 !== 4'(exp_c[i])) begin failures++; $display("FAIL post_reset_count[%0d] got=%0d exp=%0d", i, count3, exp_c[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clip();
        test_boundaries();
        test_modulus_change();
        test_prescale();
        test_reset_async();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mod_updn_counter.md
MOD_UPDN_COUNTER -- requirements
Module: mod_updn_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (2..32).
REQ-002 Parameter PRESCALE, default 1, clock cycles per count step (1..65535); 1 means a step every enabled cycle.
REQ-003 Port clk  input  1  rising-edge clock; all state changes on its rising edge except reset.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port en  input  1  count enable; gates prescaler and count steps.
REQ-006 Port up_dn  input  1  direction: 1 up, 0 down.
REQ-007 Port sat  input  1  boundary mode: 1 saturate, 0 wrap.
REQ-008 Port load  input  1  synchronous load strobe.
REQ-009 Port load_val  input  WIDTH  value loaded on load.
REQ-010 Port modulus  input  WIDTH  top count value; count range is 0..modulus inclusive.
REQ-011 Port count  output  WIDTH  registered count value.
REQ-012 Port tc  output  1  registered terminal-count pulse.
REQ-013 Port zero  output  1  combinational flag, high when count == 0.

Function
REQ-014 A step SHALL occur on a rising clk edge when en=1, load=0 and the prescaler tick is high.
REQ-015 The prescaler SHALL count 0..PRESCALE-1 while en=1, SHALL assert tick when at PRESCALE-1 with en=1, then return to 0.
REQ-016 With en=0, the prescaler and count SHALL hold their values.
REQ-017 load=1 SHALL take priority over en: count <= min(load_val, modulus); prescaler <= 0; tc <= 0.
REQ-018 Up step SHALL be count+1 when count < modulus.
REQ-019 Up step at count == modulus SHALL give 0 when sat=0, and hold modulus when sat=1.
REQ-020 Down step SHALL be count-1 when 0 < count <= modulus.
REQ-021 Down step at count == 0 SHALL give modulus when sat=0, and hold 0 when sat=1.
REQ-022 If count > modulus (modulus lowered at runtime), the next step SHALL give 0 when up, or modulus when down, regardless of sat.
REQ-023 tc SHALL be 1 for exactly one cycle after a step taken from the boundary in the step direction (count == modulus for up, count == 0 for down), in both wrap and saturate modes; otherwise 0.
REQ-024 modulus == 0 SHALL hold count at 0 and assert tc after every step.
REQ-025 Changes to up_dn, sat or modulus SHALL take effect on the next step with no extra latency.
REQ-026 Step latency SHALL be one clk edge from the qualifying tick to the updated count.
REQ-027 Arithmetic SHALL be unsigned, modulo 2^WIDTH, with no internal carry beyond WIDTH bits.

Reset
REQ-028 Asserting reset SHALL immediately force count=0, tc=0 and prescaler=0, independent of clk.
REQ-029 While reset=1, all inputs SHALL be ignored.
REQ-030 Reset deassertion is synchronised externally; the first step SHALL occur no earlier than PRESCALE enabled cycles after release.
REQ-031 Reset asserted mid-prescale or during load SHALL discard the pending operation.

Structure
REQ-032 Shared package counter_pkg SHALL hold the direction constants DIR_UP=1 and DIR_DOWN=0, the mode constants MODE_WRAP=0 and MODE_SAT=1, and the default WIDTH.
REQ-033 The prescaler SHALL be a separate sub-module, prescaler_tick (parameter PRESCALE; ports clk, reset, en, clr, tick).
REQ-034 All counter flops SHALL share clk; ripple or derived clocks are prohibited.

Verification
REQ-035 WIDTH=4, modulus=9, sat=0, up, en=1, 12 cycles from reset -> count 1..9,0,1,2; tc high for one cycle, the cycle after 9->0.
REQ-036 Down, sat=1, load_val=2 -> count 2,1,0,0,0; tc high after each step taken at 0; zero=1 from the third value onward.
REQ-037 load_val=15 with modulus=9 -> count=9; then up step with sat=0 -> 0 with tc pulse.
REQ-038 PRESCALE=3, up, modulus=15 -> count increments every 3rd enabled cycle; en low for 2 cycles mid-prescale freezes phase.
REQ-039 count=7, modulus changed to 4, up -> 0; repeat with down -> 4.
REQ-040 reset asserted between clk edges at count=5 -> count=0, tc=0 immediately; after release with PRESCALE=3, first step lands on the 3rd enabled edge.
